// File: rtl/instr_mem_writer_pkg.sv
// Shared opcodes, FSM encoding and instruction constants for the instruction-memory writer.
package instr_mem_writer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [BYTE_W-1:0] CMD_LOAD   = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_COMMIT = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_CLEAR  = 8'h03;

  localparam logic [INSTR_W-1:0] BLOCK_INSTR_NOP = 8'h00;
  localparam logic [DATA_W-1:0]  NOP_WORD        = DATA_W'(BLOCK_INSTR_NOP);

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_L_ADDR = 3'd1,
    S_L_CNT  = 3'd2,
    S_L_DATA = 3'd3,
    S_C_ARG  = 3'd4,
    S_CLEAR  = 3'd5
  } state_t;

endpackage

// File: rtl/instr_mem_writer_byte_word_assembler.sv
// Packs four host bytes, little-endian, into one 32-bit word; flags the completing byte.
module instr_mem_writer_byte_word_assembler
  import instr_mem_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              word_valid_c,
  output logic [DATA_W-1:0] word_c
);

  localparam int unsigned SR_W = DATA_W - BYTE_W;

  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [SR_W-1:0] sr_q, sr_d;

  // Earlier bytes drift toward bit 0 so the first byte lands in bits 7:0.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    if (clr) begin
      byte_cnt_d = 2'd0;
    end else if (byte_en) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      sr_d       = {in_byte, sr_q[SR_W-1:BYTE_W]};
    end
  end

  assign word_valid_c = byte_en && !clr && (byte_cnt_q == 2'd3);
  assign word_c       = {in_byte, sr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= 2'd0;
      sr_q       <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
    end
  end

endmodule

// File: rtl/instr_mem_writer.sv
// Host byte-stream command parser that loads/clears instruction RAM and publishes program length.
module instr_mem_writer
  import instr_mem_writer_pkg::*;
#(
  parameter  int unsigned n_blocks = 256,
  localparam int unsigned AW       = $clog2(n_blocks)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [AW-1:0]     n_blocks_running,
  output logic [AW-1:0]     last_block,
  output logic              fetch_reset,
  output logic              busy,
  output logic              cmd_error
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(n_blocks - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [BYTE_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]     run_q, run_d;
  logic [AW-1:0]     last_q, last_d;
  logic              fetch_reset_q, fetch_reset_d;
  logic              cmd_error_q, cmd_error_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              word_valid_c;
  logic [DATA_W-1:0] word_c;

  assign in_ready = !reset && (state_q != S_CLEAR);
  assign accept   = in_valid && in_ready;

  instr_mem_writer_byte_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr          (state_q != S_L_DATA),
    .byte_en      (accept && (state_q == S_L_DATA)),
    .in_byte      (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    run_d         = run_q;
    last_d        = last_q;
    fetch_reset_d = 1'b0;
    cmd_error_d   = 1'b0;

    case (state_q)
      S_CMD: begin
        if (accept) begin
          case (in_data)
            CMD_LOAD: begin
              state_d = S_L_ADDR;
              run_d   = '0;
            end
            CMD_COMMIT: state_d = S_C_ARG;
            CMD_CLEAR: begin
              // First NOP write goes out with the halt so both are visible together.
              state_d   = S_CLEAR;
              run_d     = '0;
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = NOP_WORD;
            end
            default: cmd_error_d = 1'b1;
          endcase
        end
      end
      S_L_ADDR: begin
        if (accept) begin
          addr_d  = AW'(in_data);
          state_d = S_L_CNT;
        end
      end
      S_L_CNT: begin
        if (accept) begin
          cnt_d   = in_data;
          state_d = S_L_DATA;
        end
      end
      S_L_DATA: begin
        if (word_valid_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = word_c;
          addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          if (cnt_q == '0) begin
            state_d = S_CMD;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_C_ARG: begin
        if (accept) begin
          state_d = S_CMD;
          if (in_data == '0) begin
            run_d = '0;
          end else if (DATA_W'(in_data) >= n_blocks) begin
            // Lengths beyond the RAM saturate to the full RAM.
            run_d         = LAST_ADDR;
            last_d        = LAST_ADDR;
            fetch_reset_d = 1'b1;
          end else begin
            run_d         = AW'(in_data);
            last_d        = AW'(in_data - 8'd1);
            fetch_reset_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        // Leave only after the final write has been on the port for its cycle.
        if (wr_addr_q == LAST_ADDR) begin
          state_d = S_CMD;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          wr_data_d = NOP_WORD;
        end
      end
      default: state_d = S_CMD;
    endcase

    busy_d = (state_d != S_CMD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_CMD;
      addr_q        <= '0;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      run_q         <= '0;
      last_q        <= '0;
      fetch_reset_q <= 1'b0;
      cmd_error_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      run_q         <= run_d;
      last_q        <= last_d;
      fetch_reset_q <= fetch_reset_d;
      cmd_error_q   <= cmd_error_d;
      busy_q        <= busy_d;
    end
  end

  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign n_blocks_running = run_q;
  assign last_block       = last_q;
  assign fetch_reset      = fetch_reset_q;
  assign cmd_error        = cmd_error_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_instr_mem_writer.sv
// Directed bench for instr_mem_writer: load, wrap, commit, clear, bad opcode, mid-word reset.
module tb_instr_mem_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  n_blocks_running;
  logic [7:0]  last_block;
  logic        fetch_reset;
  logic        busy;
  logic        cmd_error;

  int errors = 0;
  int checks = 0;
  int wr_total = 0;

  localparam logic [31:0] NOP32 = 32'h0000_0000;

  instr_mem_writer #(.n_blocks(256)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .n_blocks_running (n_blocks_running),
    .last_block       (last_block),
    .fetch_reset      (fetch_reset),
    .busy             (busy),
    .cmd_error        (cmd_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) wr_total++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and returns #1 after the edge that accepts it.
  task automatic put(input logic [7:0] b);
    int waited;
    waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 1000) begin
      tick();
      waited++;
    end
    if (waited >= 1000) chk("put_timeout", 32'(waited), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int clr_wr;
    int clr_low;
    int bad_seq;
    int cyc;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick(); tick();

    chk("rst_wr_en",   32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_nbr",     32'(n_blocks_running), 32'd0);
    chk("rst_last",    32'(last_block), 32'd0);
    chk("rst_fetch",   32'(fetch_reset), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_cmderr",  32'(cmd_error), 32'd0);
    chk("rst_ready",   32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Start a program running so the LOAD halt is observable.
    put(8'h02);
    chk("c4_busy", 32'(busy), 32'd1);
    put(8'h04);
    chk("c4_nbr",   32'(n_blocks_running), 32'd4);
    chk("c4_last",  32'(last_block), 32'd3);
    chk("c4_fetch", 32'(fetch_reset), 32'd1);
    tick();
    chk("c4_fetch_pulse", 32'(fetch_reset), 32'd0);

    // LOAD two words at address 5.
    put(8'h01);
    chk("ld_halt", 32'(n_blocks_running), 32'd0);
    put(8'h05); put(8'h01);
    put(8'hEF); put(8'hBE); put(8'hAD);
    chk("ld_no_early_wr", 32'(wr_en), 32'd0);
    put(8'hDE);
    chk("ld_w0_en",   32'(wr_en), 32'd1);
    chk("ld_w0_addr", 32'(wr_addr), 32'd5);
    chk("ld_w0_data", wr_data, 32'hDEADBEEF);
    put(8'h78);
    chk("ld_w0_one_cycle", 32'(wr_en), 32'd0);
    put(8'h56); put(8'h34); put(8'h12);
    chk("ld_w1_en",   32'(wr_en), 32'd1);
    chk("ld_w1_addr", 32'(wr_addr), 32'd6);
    chk("ld_w1_data", wr_data, 32'h12345678);
    tick();
    chk("ld_w1_one_cycle", 32'(wr_en), 32'd0);
    chk("ld_idle_busy", 32'(busy), 32'd0);
    chk("ld_nbr_still0", 32'(n_blocks_running), 32'd0);

    // Address wrap 255 -> 0, back-to-back bytes.
    put(8'h01); put(8'hFF); put(8'h01);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    chk("wrap_w0_addr", 32'(wr_addr), 32'd255);
    chk("wrap_w0_data", wr_data, 32'h44332211);
    put(8'h55); put(8'h66); put(8'h77); put(8'h88);
    chk("wrap_w1_en",   32'(wr_en), 32'd1);
    chk("wrap_w1_addr", 32'(wr_addr), 32'd0);
    chk("wrap_w1_data", wr_data, 32'h88776655);

    // COMMIT n=3 then n=0.
    put(8'h02); put(8'h03);
    chk("c3_nbr",   32'(n_blocks_running), 32'd3);
    chk("c3_last",  32'(last_block), 32'd2);
    chk("c3_fetch", 32'(fetch_reset), 32'd1);
    tick();
    chk("c3_fetch_pulse", 32'(fetch_reset), 32'd0);
    put(8'h02); put(8'h00);
    chk("c0_nbr",   32'(n_blocks_running), 32'd0);
    chk("c0_last",  32'(last_block), 32'd2);
    chk("c0_fetch", 32'(fetch_reset), 32'd0);

    // Unknown opcode, then the next byte must be parsed as an opcode.
    put(8'h7F);
    chk("bad_cmderr", 32'(cmd_error), 32'd1);
    chk("bad_busy",   32'(busy), 32'd0);
    chk("bad_no_wr",  32'(wr_en), 32'd0);
    tick();
    chk("bad_pulse", 32'(cmd_error), 32'd0);
    put(8'h02); put(8'h05);
    chk("bad_next_nbr",  32'(n_blocks_running), 32'd5);
    chk("bad_next_last", 32'(last_block), 32'd4);

    // CLEAR with the next byte (COMMIT) held on the bus throughout.
    put(8'h03);
    chk("clr_halt", 32'(n_blocks_running), 32'd0);
    in_data  = 8'h02;
    in_valid = 1'b1;
    clr_wr  = 0;
    clr_low = 0;
    bad_seq = 0;
    cyc     = 0;
    while (!in_ready && cyc < 300) begin
      if (!wr_en || wr_addr != 8'(clr_wr) || wr_data != NOP32) bad_seq++;
      if (wr_en) clr_wr++;
      clr_low++;
      tick();
      cyc++;
    end
    chk("clr_bound",     32'(cyc < 300), 32'd1);
    chk("clr_writes",    32'(clr_wr), 32'd256);
    chk("clr_ready_low", 32'(clr_low), 32'd256);
    chk("clr_seq",       32'(bad_seq), 32'd0);
    chk("clr_done_wr",   32'(wr_en), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("clr_held_accept", 32'(busy), 32'd1);
    put(8'h07);
    chk("clr_commit_nbr",  32'(n_blocks_running), 32'd7);
    chk("clr_commit_last", 32'(last_block), 32'd6);

    // Reset two bytes into a word: nothing written, new LOAD starts clean.
    put(8'h01); put(8'h10); put(8'h00);
    put(8'hAA); put(8'hBB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_no_wr", 32'(wr_en), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_nbr",   32'(n_blocks_running), 32'd0);
    tick(); tick();
    chk("mid_rst_idle_no_wr", 32'(wr_en), 32'd0);
    put(8'h01); put(8'h20); put(8'h00);
    put(8'h01); put(8'h02); put(8'h03);
    chk("post_rst_no_early", 32'(wr_en), 32'd0);
    put(8'h04);
    chk("post_rst_en",   32'(wr_en), 32'd1);
    chk("post_rst_addr", 32'(wr_addr), 32'h20);
    chk("post_rst_data", wr_data, 32'h04030201);
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("total_writes", 32'(wr_total), 32'd261);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
